// File: rtl/one_to_eight_deserializer.sv
// rtl/one_to_eight_deserializer.sv - 1:8 serial-to-byte deserializer with single-entry output hold
module one_to_eight_deserializer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       out_ready,
    output logic [7:0] OUT,
    output logic       out_valid,
    output logic [2:0] sel,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [6:0] slots_q, slots_d;
    logic [7:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       overrun_q, overrun_d;

    logic accept;
    logic complete;
    logic consume;
    logic load;
    logic drop;

    assign accept   = in_valid & ~clr;
    assign complete = accept & (sel_q == 3'd7);
    assign consume  = out_valid_q & out_ready;
    // A finished byte may load when the holding register is empty or emptied on this same edge.
    assign load     = complete & (~out_valid_q | out_ready);
    assign drop     = complete & out_valid_q & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = (sel_q == 3'd7) ? IDLE : COLLECT;
        end
    end

    always_comb begin
        busy = (state_q == COLLECT);
    end

    always_comb begin
        sel_d       = sel_q;
        slots_d     = slots_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (clr) begin
            sel_d = 3'd0;
        end else if (accept) begin
            sel_d = sel_q + 3'd1;
            if (sel_q != 3'd7) begin
                slots_d[sel_q] = in_bit;
            end
        end

        if (load) begin
            out_d       = {in_bit, slots_q};
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            overrun_d = 1'b0;
        end else if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= 3'd0;
            slots_q     <= 7'd0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            slots_q     <= slots_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign OUT       = out_q;
    assign out_valid = out_valid_q;
    assign sel       = sel_q;
    assign overrun   = overrun_q;

endmodule
